// File: rtl/iob_cycle.sv
// I/O-bus cycle sequencer: address/data strobe timing, device wait and acknowledge.
// Optional IOB_TIMEOUT_EN adds a WAITDEV timeout that terminates the cycle with IOBERR.
module iob_cycle #(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned STROBE_CYC  = 4,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic CLK,
    input  logic nRES,
    input  logic ASActive,
    input  logic IOCS,
    input  logic IACS,
    input  logic nWE,
    input  logic IOWait,
    output logic nIOAS,
    output logic nIODS,
    output logic IORnW,
    output logic IOIACK,
    output logic IOACK,
    output logic IOBERR,
    output logic IOBusy
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        WAITDEV,
        HOLD,
        ACK
    } state_t;

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    state_t     state;
    logic [3:0] cnt;
    // Aborted cycles pass through HOLD but must never reach ACK.
    logic       aborted;

`ifdef IOB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] tcnt;
    logic       err;
    logic       berr;
    assign IOBERR = berr;
`else
    assign IOBERR = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            state   <= IDLE;
            cnt     <= '0;
            aborted <= 1'b0;
            nIOAS   <= 1'b1;
            nIODS   <= 1'b1;
            IORnW   <= 1'b1;
            IOIACK  <= 1'b0;
            IOACK   <= 1'b0;
            IOBusy  <= 1'b0;
`ifdef IOB_TIMEOUT_EN
            tcnt    <= '0;
            err     <= 1'b0;
            berr    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (ASActive && IOCS) begin
                        state   <= SETUP;
                        cnt     <= SETUP_LD;
                        aborted <= 1'b0;
                        IORnW   <= nWE;
                        IOIACK  <= IACS;
                        nIOAS   <= 1'b0;
                        IOBusy  <= 1'b1;
                    end
                end
                SETUP: begin
                    if (!ASActive) begin
                        state   <= HOLD;
                        cnt     <= HOLD_LD;
                        aborted <= 1'b1;
                        nIOAS   <= 1'b1;
                        nIODS   <= 1'b1;
                    end else if (cnt == '0) begin
                        state <= STROBE;
                        cnt   <= STROBE_LD;
                        nIODS <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                STROBE: begin
                    if (!ASActive) begin
                        state   <= HOLD;
                        cnt     <= HOLD_LD;
                        aborted <= 1'b1;
                        nIOAS   <= 1'b1;
                        nIODS   <= 1'b1;
                    end else if (cnt == '0) begin
                        if (IOWait) begin
                            state <= WAITDEV;
`ifdef IOB_TIMEOUT_EN
                            tcnt  <= '0;
`endif
                        end else begin
                            state <= HOLD;
                            cnt   <= HOLD_LD;
                            nIOAS <= 1'b1;
                            nIODS <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WAITDEV: begin
                    if (!ASActive) begin
                        state   <= HOLD;
                        cnt     <= HOLD_LD;
                        aborted <= 1'b1;
                        nIOAS   <= 1'b1;
                        nIODS   <= 1'b1;
                    end else if (!IOWait) begin
                        state <= HOLD;
                        cnt   <= HOLD_LD;
                        nIOAS <= 1'b1;
                        nIODS <= 1'b1;
`ifdef IOB_TIMEOUT_EN
                    end else if (tcnt == TO_LAST) begin
                        state <= HOLD;
                        cnt   <= HOLD_LD;
                        err   <= 1'b1;
                        nIOAS <= 1'b1;
                        nIODS <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 8'd1;
`endif
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        if (ASActive && !aborted) begin
                            state <= ACK;
`ifdef IOB_TIMEOUT_EN
                            IOACK <= !err;
                            berr  <= err;
`else
                            IOACK <= 1'b1;
`endif
                        end else begin
                            state  <= IDLE;
                            IOBusy <= 1'b0;
`ifdef IOB_TIMEOUT_EN
                            err    <= 1'b0;
`endif
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACK: begin
                    if (!ASActive) begin
                        state  <= IDLE;
                        IOACK  <= 1'b0;
                        IOBusy <= 1'b0;
`ifdef IOB_TIMEOUT_EN
                        berr   <= 1'b0;
                        err    <= 1'b0;
`endif
                    end
                end
                default: begin
                    state  <= IDLE;
                    nIOAS  <= 1'b1;
                    nIODS  <= 1'b1;
                    IOACK  <= 1'b0;
                    IOBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iob_cycle.sv
// Self-checking bench for iob_cycle: per-cycle expected strobe/ack timeline derived
// from the setup/strobe/wait/hold cycle counts, with randomized cycle shapes.
module tb_iob_cycle;

    localparam int S  = 1;
    localparam int T  = 4;
    localparam int H  = 1;
    localparam int TO = 64;

    logic CLK = 1'b0;
    logic nRES = 1'b0;
    logic ASActive = 1'b0;
    logic IOCS = 1'b0;
    logic IACS = 1'b0;
    logic nWE = 1'b1;
    logic IOWait = 1'b0;
    logic nIOAS, nIODS, IORnW, IOIACK, IOACK, IOBERR, IOBusy;
    logic [6:0] obs;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    assign obs = {nIOAS, nIODS, IORnW, IOIACK, IOACK, IOBERR, IOBusy};

    iob_cycle #(
        .SETUP_CYC  (S),
        .STROBE_CYC (T),
        .HOLD_CYC   (H),
        .TIMEOUT_CYC(TO)
    ) dut (
        .CLK     (CLK),
        .nRES    (nRES),
        .ASActive(ASActive),
        .IOCS    (IOCS),
        .IACS    (IACS),
        .nWE     (nWE),
        .IOWait  (IOWait),
        .nIOAS   (nIOAS),
        .nIODS   (nIODS),
        .IORnW   (IORnW),
        .IOIACK  (IOIACK),
        .IOACK   (IOACK),
        .IOBERR  (IOBERR),
        .IOBusy  (IOBusy)
    );

    // One full cycle from accept (edge 0) to return to IDLE. wd = WAITDEV cycles the
    // device requests; abort_at = edge index at which ASActive is first sampled low (0 = none).
    task automatic run_cycle(input string tag, input logic nwe, input logic iacs,
                             input int wd, input int abort_at, input int ack_len);
        int err_exp, wde, strobe_end, ack_start, idle_start, as_end, e;
        logic as_low, ack_any, busy;
        logic [6:0] expv;
`ifdef IOB_TIMEOUT_EN
        err_exp = (wd > TO) ? 1 : 0;
`else
        err_exp = 0;
`endif
        wde        = (err_exp != 0) ? TO : wd;
        strobe_end = S + T + wde;
        ack_start  = strobe_end + H;
        if (abort_at > 0) begin
            as_end     = abort_at;
            idle_start = abort_at + H;
        end else begin
            as_end     = strobe_end;
            idle_start = ack_start + ack_len;
        end
        ASActive = 1'b1;
        IOCS     = 1'b1;
        nWE      = nwe;
        IACS     = iacs;
        IOWait   = 1'($urandom);
        for (int k = 0; k <= idle_start; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            busy    = (k < idle_start);
            as_low  = (k < as_end);
            ack_any = (abort_at == 0) && (k >= ack_start) && (k < idle_start);
            expv = {!as_low, !(as_low && k >= S), nwe, iacs,
                    ack_any && (err_exp == 0), ack_any && (err_exp != 0), busy};
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL %s k=%0d outs{nIOAS,nIODS,IORnW,IOIACK,IOACK,IOBERR,IOBusy} got %b want %b",
                         tag, k, obs, expv);
            end
            e = k + 1;
            ASActive = (abort_at > 0) ? (e < abort_at) : (e < idle_start);
            IOCS     = 1'($urandom);
            nWE      = 1'($urandom);
            IACS     = 1'($urandom);
            if (e < S + T) IOWait = 1'($urandom);
            else           IOWait = (e < S + T + wd);
        end
        ASActive = 1'b0;
        IOWait   = 1'b0;
    endtask

    task automatic test_reset();
        nRES = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (obs !== 7'b1110000) begin
            errors++;
            $display("FAIL reset_hold outs got %b want %b", obs, 7'b1110000);
        end
        nRES = 1'b1;
        @(negedge CLK);
        checks++;
        if (obs !== 7'b1110000) begin
            errors++;
            $display("FAIL reset_release outs got %b want %b", obs, 7'b1110000);
        end
    endtask

    task automatic test_basic_read();
        run_cycle("basic_read", 1'b1, 1'b0, 0, 0, 3);
    endtask

    task automatic test_write_wait();
        run_cycle("write_wait", 1'b0, 1'b0, 7, 0, 2);
    endtask

    task automatic test_abort();
        run_cycle("abort_strobe2", 1'b1, 1'b0, 0, 3, 0);
        run_cycle("abort_setup", 1'b0, 1'b0, 0, 1, 0);
        run_cycle("abort_waitdev", 1'b1, 1'b1, 5, S + T + 2, 0);
    endtask

    task automatic test_iack();
        run_cycle("iack_on", 1'b1, 1'b1, 0, 0, 1);
        run_cycle("iack_off", 1'b1, 1'b0, 0, 0, 1);
    endtask

    task automatic test_no_select();
        for (int i = 0; i < 8; i++) begin
            ASActive = (i < 4);
            IOCS     = (i >= 4);
            nWE      = 1'($urandom);
            IACS     = 1'($urandom);
            @(posedge CLK);
            @(negedge CLK);
            checks++;
            if ({nIOAS, nIODS, IOACK, IOBERR, IOBusy} !== 5'b11000) begin
                errors++;
                $display("FAIL no_select i=%0d outs{nIOAS,nIODS,IOACK,IOBERR,IOBusy} got %b want %b",
                         i, {nIOAS, nIODS, IOACK, IOBERR, IOBusy}, 5'b11000);
            end
        end
        ASActive = 1'b0;
        IOCS     = 1'b0;
    endtask

    task automatic test_timeout();
        // Device wait stuck high for 1000 cycles: timeout build terminates with IOBERR,
        // default build stays in WAITDEV throughout and then completes normally.
        run_cycle("timeout", 1'b1, 1'b0, 1000, 0, 2);
    endtask

    task automatic test_reset_waitdev();
        ASActive = 1'b1;
        IOCS     = 1'b1;
        nWE      = 1'b0;
        IACS     = 1'b1;
        IOWait   = 1'b1;
        repeat (S + T + 3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (obs !== 7'b0001001) begin
            errors++;
            $display("FAIL rst_wait_pre outs got %b want %b", obs, 7'b0001001);
        end
        #1 nRES = 1'b0;
        #1;
        checks++;
        if (obs !== 7'b1110000) begin
            errors++;
            $display("FAIL rst_wait_async outs got %b want %b", obs, 7'b1110000);
        end
        @(negedge CLK);
        nRES     = 1'b1;
        ASActive = 1'b0;
        IOWait   = 1'b0;
        @(negedge CLK);
        checks++;
        if (obs !== 7'b1110000) begin
            errors++;
            $display("FAIL rst_wait_idle outs got %b want %b", obs, 7'b1110000);
        end
        run_cycle("rst_wait_nominal", 1'b1, 1'b0, 0, 0, 1);
    endtask

    task automatic test_back_to_back();
        int wd, ab, al, se;
        logic nwe, iacs;
        for (int i = 0; i < 40; i++) begin
            nwe  = 1'($urandom);
            iacs = 1'($urandom);
            wd   = int'($urandom_range(0, 6));
            al   = int'($urandom_range(1, 3));
            se   = S + T + wd;
            ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, se)) : 0;
            run_cycle("back_to_back", nwe, iacs, wd, ab, al);
        end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_write_wait();
        test_abort();
        test_iack();
        test_no_select();
        test_timeout();
        test_reset_waitdev();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iob_cycle.md
IOB_CYCLE -- requirements
Module: iob_cycle

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 1, meaning cycles nIOAS is low before nIODS falls (range 1..15).
REQ-002 SHALL have parameter STROBE_CYC, default 4, meaning minimum cycles nIODS is low (range 1..15).
REQ-003 SHALL have parameter HOLD_CYC, default 1, meaning cycles after both strobes rise before the cycle completes (range 1..15).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 64, meaning device-wait cycles before bus error (range 2..255; used only with IOB_TIMEOUT_EN).
REQ-005 SHALL have port CLK, input, 1, the single clock, with all state updating on its rising edge.
REQ-006 SHALL have port nRES, input, 1, reset that is asynchronous and active-low.
REQ-007 SHALL have port ASActive, input, 1, front-side address strobe active.
REQ-008 SHALL have port IOCS, input, 1, I/O-bus domain select from the chip-select decoder.
REQ-009 SHALL have port IACS, input, 1, interrupt-acknowledge select.
REQ-010 SHALL have port nWE, input, 1, front-side write strobe (low = write).
REQ-011 SHALL have port IOWait, input, 1, device wait request (high = extend the strobe).
REQ-012 SHALL have port nIOAS, output, 1, I/O-bus address strobe (active-low).
REQ-013 SHALL have port nIODS, output, 1, I/O-bus data strobe (active-low).
REQ-014 SHALL have port IORnW, output, 1, latched direction (1 = read).
REQ-015 SHALL have port IOIACK, output, 1, latched interrupt-acknowledge cycle flag.
REQ-016 SHALL have port IOACK, output, 1, cycle-complete acknowledge to the front side.
REQ-017 SHALL have port IOBERR, output, 1, bus-error termination to the front side.
REQ-018 SHALL have port IOBusy, output, 1, high in every state except IDLE.

Function
REQ-019 SHALL implement the states IDLE, SETUP, STROBE, WAITDEV, HOLD and ACK, with all outputs registered.
REQ-020 SHALL, in IDLE, accept a cycle when ASActive&&IOCS is sampled high: latch IORnW<=nWE and IOIACK<=IACS, load the down-counter with SETUP_CYC-1, and go to SETUP.
REQ-021 SHALL hold nIOAS low in SETUP, STROBE and WAITDEV, and high otherwise.
REQ-022 SHALL hold nIODS low in STROBE and WAITDEV, and high otherwise.
REQ-023 SHALL, in SETUP with counter==0, go to STROBE with the counter loaded to STROBE_CYC-1; otherwise it SHALL decrement the counter.
REQ-024 SHALL, in STROBE with counter==0, go to WAITDEV if IOWait is high, else go to HOLD with the counter loaded to HOLD_CYC-1.
REQ-025 SHALL remain in WAITDEV while IOWait is high, and go to HOLD on the first edge that samples IOWait low.
REQ-026 SHALL, in HOLD with counter==0, go to ACK if ASActive is high, or go to IDLE if ASActive is low.
REQ-027 SHALL, in ACK, assert IOACK (or IOBERR if the error flag is set, never both), and go to IDLE on the first edge with ASActive low.
REQ-028 SHALL make the accept-to-IOACK latency exactly SETUP_CYC+STROBE_CYC+HOLD_CYC edges when IOWait is low.
REQ-029 SHALL, on abort (ASActive sampled low in SETUP, STROBE or WAITDEV), go directly to HOLD (strobes rise), and then to IDLE without asserting IOACK or IOBERR.
REQ-030 SHALL not accept a new cycle on the same edge that leaves ACK; IDLE lasts at least one cycle.
REQ-031 SHALL ignore IOCS whenever the state is not IDLE.

Reset
REQ-032 SHALL, while nRES is low, immediately force the following outputs: state IDLE, counter 0, error flag 0, nIOAS=1, nIODS=1, IORnW=1, IOIACK=0, IOACK=0, IOBERR=0, IOBusy=0.
REQ-033 SHALL, on reset mid-cycle, drop the strobes with no acknowledge, and accept a new cycle only after nRES has been high for one edge.

Configuration
REQ-034 SHALL, with IOB_TIMEOUT_EN defined, count WAITDEV cycles and, when TIMEOUT_CYC consecutive cycles are reached, set the error flag and go to HOLD; the flag SHALL clear on entry to IDLE.
REQ-035 SHALL, without IOB_TIMEOUT_EN, wait in WAITDEV indefinitely, tie IOBERR to 0, and contain no timeout counter logic.

Verification
REQ-036 Basic read, defaults: ASActive=IOCS=1, nWE=1 at edge 0 -> nIOAS low at edges 1-5, nIODS low at edges 2-5, IOACK high after edge 6 until ASActive falls, IORnW=1.
REQ-037 Write with wait: nWE=0, IOWait=1 held for 10 cycles after strobe entry -> nIODS low for 4+7 cycles, IOACK after edge 13, IORnW=0.
REQ-038 Abort: ASActive falls during STROBE count 2 -> HOLD next edge, IDLE after HOLD, IOACK and IOBERR never asserted.
REQ-039 Timeout (IOB_TIMEOUT_EN, TIMEOUT_CYC=64): IOWait stuck high -> IOBERR asserted after 64 WAITDEV cycles plus HOLD, IOACK stays 0; without the macro, the same stimulus -> block stays in WAITDEV for 1000 cycles.
REQ-040 Reset in WAITDEV: nRES pulsed low -> nIOAS and nIODS high asynchronously, IOBusy=0, and the next accepted cycle runs at nominal latency.
REQ-041 IACK cycle: IACS=IOCS=1 -> IOIACK=1 for the whole cycle, then 0 after a following cycle with IACS=0.
